// File: rtl/ser_tx_if.sv
// ser_tx_if: handshake and serial-line bundle for the serial transmitter.
// The master side supplies words; the slave side (ser_tx) drives the line.
interface ser_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] D;     // word to send
  logic              DV;    // word valid
  logic              RDY;   // transmitter ready to accept
  logic              TXD;   // serial line, idle high
  logic              BUSY;  // frame in progress

  modport master (
    output D,
    output DV,
    input  RDY,
    input  TXD,
    input  BUSY
  );

  modport slave (
    input  D,
    input  DV,
    output RDY,
    output TXD,
    output BUSY
  );
endinterface

// File: rtl/ser_tx.sv
// ser_tx: parallel-to-serial asynchronous transmitter.
// One word per valid/ready handshake is sent as start bit, data LSB first,
// optional parity, then stop bits; every bit cell lasts DIV clocks.
// All outputs are registered, so the start bit appears on the accept edge.
module ser_tx #(
  parameter int DATA_W    = 8,   // data bits per frame (5..9)
  parameter int DIV       = 16,  // clocks per bit cell (>= 2)
  parameter int PARITY    = 0,   // 0 none, 1 even, 2 odd
  parameter int STOP_BITS = 1    // 1 or 2
) (
  input  logic     CK,
  input  logic     CD,
  ser_tx_if.slave  bus
);

  localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [TW-1:0] TIMER_LAST = TW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_W - 1);
  localparam logic [BW-1:0] STOP_LAST  = BW'(STOP_BITS - 1);
  localparam logic          HAS_PAR    = (PARITY != 0);
  localparam logic          ODD_PAR    = (PARITY == 2);

  // Illegal configurations are flagged while the design is elaborated.
  if ((PARITY < 0) || (PARITY > 2)) begin : g_bad_parity
    $error("ser_tx: PARITY must be 0, 1 or 2");
  end
  if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop
    $error("ser_tx: STOP_BITS must be 1 or 2");
  end
  if ((DATA_W < 5) || (DATA_W > 9)) begin : g_bad_width
    $error("ser_tx: DATA_W must be in 5..9");
  end
  if (DIV < 2) begin : g_bad_div
    $error("ser_tx: DIV must be at least 2");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  // Parity of a word; odd selects the inverted (odd) sense.
  function automatic logic parity_of(input logic [DATA_W-1:0] word, input logic odd);
    return (^word) ^ odd;
  endfunction

  state_t            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [BW-1:0]     bit_q,   bit_d;     // data bit index, reused as stop-bit index
  logic [DATA_W-1:0] shift_q, shift_d;   // bit 0 is the data bit on the line
  logic              par_q,   par_d;
  logic              rdy_q,   rdy_d;
  logic              txd_q,   txd_d;
  logic              busy_q,  busy_d;

  logic              accept_s;
  logic              cell_end_s;

  assign accept_s   = bus.DV & rdy_q;
  assign cell_end_s = (timer_q == TIMER_LAST);

  assign bus.RDY  = rdy_q;
  assign bus.TXD  = txd_q;
  assign bus.BUSY = busy_q;

  // Next-state and next-output logic; txd_d is the line level of the cell being entered.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    rdy_d   = rdy_q;
    txd_d   = txd_q;
    busy_d  = busy_q;

    if (state_q == S_IDLE) begin
      timer_d = {TW{1'b0}};
    end else if (cell_end_s) begin
      timer_d = {TW{1'b0}};
    end else begin
      timer_d = timer_q + TW'(1);
    end

    case (state_q)
      S_IDLE: begin
        bit_d  = {BW{1'b0}};
        txd_d  = 1'b1;
        busy_d = 1'b0;
        if (accept_s) begin
          state_d = S_START;
          shift_d = bus.D;
          par_d   = parity_of(bus.D, ODD_PAR);
          rdy_d   = 1'b0;
          txd_d   = 1'b0;
          busy_d  = 1'b1;
        end else begin
          rdy_d   = 1'b1;
        end
      end

      S_START: begin
        if (cell_end_s) begin
          state_d = S_DATA;
          bit_d   = {BW{1'b0}};
          txd_d   = shift_q[0];
        end else begin
          txd_d   = 1'b0;
        end
      end

      S_DATA: begin
        if (cell_end_s) begin
          if (bit_q == BIT_LAST) begin
            bit_d = {BW{1'b0}};
            if (HAS_PAR) begin
              state_d = S_PAR;
              txd_d   = par_q;
            end else begin
              state_d = S_STOP;
              txd_d   = 1'b1;
            end
          end else begin
            bit_d   = bit_q + BW'(1);
            shift_d = {1'b0, shift_q[DATA_W-1:1]};
            txd_d   = shift_q[1];
          end
        end else begin
          txd_d = shift_q[0];
        end
      end

      S_PAR: begin
        if (cell_end_s) begin
          state_d = S_STOP;
          bit_d   = {BW{1'b0}};
          txd_d   = 1'b1;
        end else begin
          txd_d   = par_q;
        end
      end

      S_STOP: begin
        txd_d = 1'b1;
        if (cell_end_s) begin
          if (bit_q == STOP_LAST) begin
            state_d = S_IDLE;
            bit_d   = {BW{1'b0}};
            rdy_d   = 1'b1;
            busy_d  = 1'b0;
          end else begin
            bit_d   = bit_q + BW'(1);
          end
        end else begin
          bit_d = bit_q;
        end
      end

      default: begin
        state_d = S_IDLE;
        timer_d = {TW{1'b0}};
        bit_d   = {BW{1'b0}};
        rdy_d   = 1'b0;
        txd_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any frame and holds RDY low.
  always_ff @(posedge CK) begin
    if (CD) begin
      state_q <= S_IDLE;
      timer_q <= {TW{1'b0}};
      bit_q   <= {BW{1'b0}};
      shift_q <= {DATA_W{1'b0}};
      par_q   <= 1'b0;
      rdy_q   <= 1'b0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      rdy_q   <= rdy_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
    end
  end

endmodule
